// File: rtl/core_amo_ctrl_if.sv
// core_amo_ctrl_if -- bundle of every handshake/bus signal of the AMO controller.
//
// Core side : i_amo_req_valid/o_amo_req_ready request handshake with
//             i_amo_addr, i_amo_data, i_amo_op; o_amo_resp_valid/i_amo_resp_ready
//             response handshake with o_amo_resp_data, o_amo_resp_err.
// Memory side: o_mem_req_valid/i_mem_req_ready request handshake with o_mem_we,
//             o_mem_addr, o_mem_wdata; i_mem_rsp_valid with i_mem_rsp_data and
//             i_mem_rsp_err.
// Status     : o_busy.
// Signal names carry the controller's point of view (i_ = into controller).
// modport slave  : the AMO controller itself.
// modport master : the environment (core + memory) driving the controller.
interface core_amo_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_amo_req_valid;
  logic                  o_amo_req_ready;
  logic [ADDR_WIDTH-1:0] i_amo_addr;
  logic [DATA_WIDTH-1:0] i_amo_data;
  logic [3:0]            i_amo_op;
  logic                  o_amo_resp_valid;
  logic                  i_amo_resp_ready;
  logic [DATA_WIDTH-1:0] o_amo_resp_data;
  logic                  o_amo_resp_err;
  logic                  o_mem_req_valid;
  logic                  i_mem_req_ready;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic                  i_mem_rsp_valid;
  logic [DATA_WIDTH-1:0] i_mem_rsp_data;
  logic                  i_mem_rsp_err;
  logic                  o_busy;

  modport slave (
    input  i_amo_req_valid, i_amo_addr, i_amo_data, i_amo_op, i_amo_resp_ready,
           i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err,
    output o_amo_req_ready, o_amo_resp_valid, o_amo_resp_data, o_amo_resp_err,
           o_mem_req_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );

  modport master (
    output i_amo_req_valid, i_amo_addr, i_amo_data, i_amo_op, i_amo_resp_ready,
           i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err,
    input  o_amo_req_ready, o_amo_resp_valid, o_amo_resp_data, o_amo_resp_err,
           o_mem_req_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );
endinterface

// File: rtl/core_amo_ctrl.sv
// core_amo_ctrl -- executes one atomic memory operation at a time as a
// read-modify-write sequence against a simple request/response memory port.
//
// Ports:
//   i_clk  : sole clock, rising edge.
//   i_rst  : synchronous active-high reset; abandons any transaction in flight.
//   bus    : core_amo_ctrl_if.slave -- core request/response handshakes, memory
//            request/response handshakes and o_busy (see the interface file).
//
// Flow: IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> RESP -> IDLE.
// Illegal op codes and misaligned addresses go straight IDLE -> RESP with
// an error and never touch memory. A read error skips the write.
module core_amo_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input logic           i_clk,
  input logic           i_rst,
  core_amo_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [3:0] OP_SWAP = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_MAX  = 4'h5;
  localparam logic [3:0] OP_MIN  = 4'h6;
  localparam logic [3:0] OP_MAXU = 4'h7;
  localparam logic [3:0] OP_MINU = 4'h8;

  // Low address bits that must be zero for a naturally aligned access.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  logic [2:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] data_q,      data_d;
  logic [3:0]            op_q,        op_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q,  resp_err_d;

  logic                  req_illegal;

  // Modify step of the read-modify-write. Op codes above MINU never reach
  // here because they are rejected at accept time.
  function automatic logic [DATA_WIDTH-1:0] amo_result(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] core_v
  );
    logic signed [DATA_WIDTH-1:0] old_s;
    logic signed [DATA_WIDTH-1:0] core_s;
    logic [DATA_WIDTH-1:0]        res;
    old_s  = $signed(old_v);
    core_s = $signed(core_v);
    case (op)
      OP_SWAP: res = core_v;
      OP_ADD:  res = old_v + core_v;
      OP_AND:  res = old_v & core_v;
      OP_OR:   res = old_v | core_v;
      OP_XOR:  res = old_v ^ core_v;
      OP_MAX:  res = (old_s > core_s) ? old_v : core_v;
      OP_MIN:  res = (old_s < core_s) ? old_v : core_v;
      OP_MAXU: res = (old_v > core_v) ? old_v : core_v;
      OP_MINU: res = (old_v < core_v) ? old_v : core_v;
      default: res = core_v;
    endcase
    return res;
  endfunction

  assign req_illegal = (bus.i_amo_op > OP_MINU) || ((bus.i_amo_addr & ALIGN_MASK) != '0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_amo_req_valid) begin
          addr_d      = bus.i_amo_addr;
          data_d      = bus.i_amo_data;
          op_d        = bus.i_amo_op;
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          if (req_illegal) begin
            resp_err_d = 1'b1;
            state_d    = S_RESP;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (bus.i_mem_req_ready) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (bus.i_mem_rsp_valid) begin
          resp_data_d = bus.i_mem_rsp_data;
          if (bus.i_mem_rsp_err) begin
            resp_err_d = 1'b1;
            state_d    = S_RESP;
          end else begin
            // Write data is captured once here so it stays stable under stalls.
            wdata_d = amo_result(op_q, bus.i_mem_rsp_data, data_q);
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (bus.i_mem_req_ready) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (bus.i_mem_rsp_valid) begin
          resp_err_d = bus.i_mem_rsp_err;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.i_amo_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      op_q        <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Memory-side fields are forced to zero whenever no request is presented.
  assign bus.o_amo_req_ready  = (state_q == S_IDLE);
  assign bus.o_busy           = (state_q != S_IDLE);
  assign bus.o_amo_resp_valid = (state_q == S_RESP);
  assign bus.o_amo_resp_data  = resp_data_q;
  assign bus.o_amo_resp_err   = resp_err_q;
  assign bus.o_mem_req_valid  = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign bus.o_mem_we         = (state_q == S_WR_REQ);
  assign bus.o_mem_addr       = bus.o_mem_req_valid ? addr_q : '0;
  assign bus.o_mem_wdata      = (state_q == S_WR_REQ) ? wdata_q : '0;

endmodule

// File: doc/core_amo_ctrl.md
CORE_AMO_CTRL -- requirements
Module: core_amo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, which sets the data and operand width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, which sets the memory address width.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_amo_req_valid  in  1  core AMO request valid.
REQ-006 o_amo_req_ready  out  1  block can accept a request.
REQ-007 i_amo_addr  in  ADDR_WIDTH  target address.
REQ-008 i_amo_data  in  DATA_WIDTH  core operand.
REQ-009 i_amo_op  in  4  op code: 0000 SWAP, 0001 ADD, 0010 AND, 0011 OR, 0100 XOR, 0101 MAX, 0110 MIN, 0111 MAXU, 1000 MINU.
REQ-010 o_amo_resp_valid  out  1  response valid.
REQ-011 i_amo_resp_ready  in  1  core accepts response.
REQ-012 o_amo_resp_data  out  DATA_WIDTH  original memory value.
REQ-013 o_amo_resp_err  out  1  operation failed.
REQ-014 o_mem_req_valid  out  1  memory request valid.
REQ-015 i_mem_req_ready  in  1  memory accepts request.
REQ-016 o_mem_we  out  1  1 = write, 0 = read.
REQ-017 o_mem_addr  out  ADDR_WIDTH  memory address.
REQ-018 o_mem_wdata  out  DATA_WIDTH  write data.
REQ-019 i_mem_rsp_valid  in  1  memory read data or write acknowledge valid.
REQ-020 i_mem_rsp_data  in  DATA_WIDTH  read data.
REQ-021 i_mem_rsp_err  in  1  memory error, qualified by i_mem_rsp_valid.
REQ-022 o_busy  out  1  high in every state except IDLE.

Function
REQ-023 The FSM SHALL have exactly these states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
REQ-024 o_amo_req_ready SHALL be 1 only in IDLE; a request is accepted when valid and ready are both high on a clock edge.
REQ-025 On accept, the block SHALL register addr, data and op, and clear the held response data and error.
REQ-026 On accept with op > 1000 or addr[log2(DATA_WIDTH/8)-1:0] != 0, the block SHALL go IDLE -> RESP with err=1 and resp_data=0, and SHALL issue no memory request.
REQ-027 On accept of a legal request, the block SHALL go IDLE -> RD_REQ.
REQ-028 In RD_REQ: mem_req_valid=1, we=0, addr=latched addr; held stable until i_mem_req_ready, then -> RD_WAIT.
REQ-029 In RD_WAIT, on i_mem_rsp_valid the block SHALL latch i_mem_rsp_data as the old value.
REQ-030 In RD_WAIT, on i_mem_rsp_valid with err=1 the block SHALL go -> RESP with resp_err=1 and no write; otherwise -> WR_REQ.
REQ-031 In WR_REQ: mem_req_valid=1, we=1, addr=latched addr, wdata=f(op, old, core data); held stable until i_mem_req_ready, then -> WR_WAIT.
REQ-032 f SHALL be: SWAP=core; ADD=old+core mod 2^DATA_WIDTH; AND/OR/XOR bitwise; MAX/MIN signed two's-complement compare; MAXU/MINU unsigned compare; equal operands return either operand.
REQ-033 In WR_WAIT, on i_mem_rsp_valid the block SHALL go -> RESP with resp_err=i_mem_rsp_err; resp_data SHALL remain the old value.
REQ-034 In RESP, o_amo_resp_valid=1 and resp_data/err SHALL be stable; on i_amo_resp_ready -> IDLE.
REQ-035 i_mem_rsp_valid outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-036 A response in the same cycle the request is accepted SHALL NOT be consumed; responses count only from the following cycle.
REQ-037 When not in RD_REQ or WR_REQ, mem_req_valid SHALL be 0 and we, addr, wdata SHALL be 0.
REQ-038 With zero-wait memory, accept at edge T SHALL yield o_amo_resp_valid asserted in cycle T+5.
REQ-039 Only one AMO SHALL be in flight; no new request is accepted before the response handshake completes.

Reset
REQ-040 On i_rst=1 at a clock edge the block SHALL enter IDLE from any state, including mid-transaction.
REQ-041 Reset SHALL clear all registers to 0: o_amo_req_ready=1, o_busy=0, and all other outputs 0.
REQ-042 A memory transaction in progress at reset SHALL be abandoned; the memory side SHALL be reset concurrently.

Verification
REQ-043 ADD, mem=5, core=3, zero-wait memory -> write of 8, resp_data=5, err=0, resp_valid at T+5.
REQ-044 MIN, mem=0xFFFF_FFFF_FFFF_FFFF, core=1 -> write 0xFFFF_FFFF_FFFF_FFFF; the same operands with MINU -> write 1; resp_data=0xFFFF_FFFF_FFFF_FFFF in both cases.
REQ-045 SWAP, core=0xA5, i_mem_req_ready low 3 cycles in each request state and i_amo_resp_ready low 2 cycles -> request fields stable throughout, write 0xA5, resp_data=prior mem value.
REQ-046 op=1001 or addr=0x4 -> resp_err=1, resp_data=0, mem_req_valid never asserted.
REQ-047 Read response with i_mem_rsp_err=1 -> no write issued, resp_err=1.
REQ-048 i_rst pulsed in RD_WAIT -> next cycle IDLE, all outputs at reset values, and a subsequent ADD completes correctly.
